pe_mcast_feeder: RTL and testbench
==================================

# pe_mcast_feeder

Multicast feeder that drives the `ifmap`/`filter` load ports of a group of NUM_PE processing elements. It takes tagged words from the global-buffer side through a valid/ready handshake and matches each word's tag against a per-PE configured ID. It delivers the word simultaneously to every matching PE, asserting that PE's `ifmap_enable` or `filter_enable` for one cycle. Per-PE, per-kind credit counters cap each PE's load window at BURST words, which protects against the PE's `ready` being registered and therefore stale.

## Interface
- BITWIDTH, 16, data word width (matches PE BITWIDTH)
- NUM_PE, 4, number of PE destinations
- ID_WIDTH, 4, tag/ID width
- BURST, 3, max words of one kind per PE per ready window (equals the PE filter size)
- CNT_WIDTH, 8, drop counter width
- Reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock, all state updates on rising edge
- rstb  in  1  synchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_idx  in  clog2(NUM_PE)  PE index written
- cfg_id  in  ID_WIDTH  ID for that PE
- cfg_en  in  1  PE participates in matching when 1
- in_valid  in  1  upstream word valid
- in_ready  out  1  feeder can accept a word this cycle
- in_data  in  BITWIDTH  signed data word
- in_tag  in  ID_WIDTH  destination tag
- in_is_filter  in  1  1 = filter word, 0 = ifmap word
- pe_ready  in  NUM_PE  per-PE `ready` from each PE
- ifmap_out  out  BITWIDTH  ifmap bus shared by all PEs
- filter_out  out  BITWIDTH  filter bus shared by all PEs
- ifmap_enable  out  NUM_PE  per-PE ifmap load strobe
- filter_enable  out  NUM_PE  per-PE filter load strobe
- drop_count  out  CNT_WIDTH  number of words that matched no PE (saturating)

## Operation
- Config registers: id[i] and en[i], written at the edge where cfg_we=1. The new value is visible the next cycle. Reset: all id=0, en=0.
- Holding buffer: one entry with buf_valid, buf_data, buf_tag and buf_kind.
- mask[i] = en[i] && (id[i]==buf_tag). This is combinational from the current config, so a config write while a word is held changes that word's mask.
- Credit: sent[i][k] counts words sent to PE i for kind k (ifmap/filter). It is 0..BURST.
- eff_rdy[i][k] = pe_ready[i] && sent[i][k] < BURST.
- fire = buf_valid && (mask==0 || every PE i with mask[i]=1 has eff_rdy[i][buf_kind]=1). Delivery is all-or-nothing; there are no partial multicasts.
- in_ready = !buf_valid || fire.
- Accept: in_valid && in_ready loads the buffer. A simultaneous fire and accept replaces the entry, giving 1 word/cycle throughput.
- On fire with mask != 0:
  - Next cycle, `<kind>_enable` = mask for exactly one cycle; the other kind's enable is 0.
  - The `<kind>_out` bus is loaded with buf_data; the other bus holds its value.
  - sent[i][kind]++ for each masked PE.
- On fire with mask == 0: the word is dropped, no enables are asserted, and drop_count increments, saturating at 2^CNT_WIDTH-1.
- Credit refill:
  - At any edge where pe_ready[i]=0, sent[i][0] and sent[i][1] are cleared to 0.
  - A refill cannot coincide with an increment, because fire requires pe_ready=1.
  - A PE that holds ready high throughout never receives more than BURST words of a kind.

## Timing
- Reset (rstb low at an edge): buf_valid=0, all enables=0, ifmap_out=filter_out=0, drop_count=0, all sent=0, config cleared. in_ready=0 while rstb=0 and 1 in the first cycle after release. Reset mid-delivery discards the held word and any pending enable.
- Latency: word accepted at edge N; fire evaluated in cycle N..; enable and data visible in the cycle after the fire edge. Minimum accept-to-enable is 1 cycle when the destinations are ready.
- Enables are registered, one-cycle pulses. Data is stable on the bus in every cycle its enable is high.
- in_ready is combinational from buf_valid, pe_ready and config; there is no combinational path from in_valid.
- Back-pressure: while any masked PE lacks credit or ready, the word is held, in_ready=0, and the upstream must hold data stable.

## Test plan
- Unicast: id={1,2,3,4}, all en=1, pe_ready=all 1; send ifmap tag 2, data 0x0007 → next cycle ifmap_enable=4'b0010, ifmap_out=0x0007, filter_enable=0.
- Multicast plus partial ready: id={5,5,5,1}, pe_ready=4'b1011; send filter tag 5, data -3 → held, in_ready=0. Raise pe_ready[2] → next cycle filter_enable=4'b0111, filter_out=0xFFFD.
- Credit limit: one PE, id=0, pe_ready held 1; stream 5 ifmap words 10..14 → exactly 3 enable pulses (10, 11, 12), word 13 held. Drop pe_ready for 1 cycle and restore it → 13 and 14 are delivered.
- Drop: send tag 9 with no matching ID, 3 times back-to-back → no enables, drop_count=3, in_ready stays 1, 1 word/cycle.
- Back-to-back throughput: filter, ifmap, filter to tag 1, always ready → enables in 3 consecutive cycles, each bus updates only on its own kind.
- Sync reset mid-hold: word held waiting for ready, assert rstb=0 for 1 cycle → buffer empty, enables 0, drop_count=0, in_ready=1 in the cycle after release, no later delivery of the discarded word.

Source files
------------

// File: rtl/pe_mcast_feeder_if.sv
// Upstream word stream into the multicast feeder.
//   in_valid     : word valid (source -> feeder)
//   in_ready     : feeder can take a word this cycle (feeder -> source)
//   in_data      : signed data word
//   in_tag       : destination tag matched against per-PE IDs
//   in_is_filter : 1 = filter word, 0 = ifmap word
interface pe_mcast_feeder_if #(
    parameter int unsigned BITWIDTH = 16,
    parameter int unsigned ID_WIDTH = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] in_data;
    logic [ID_WIDTH-1:0] in_tag;
    logic                in_is_filter;

    modport master (output in_valid, in_data, in_tag, in_is_filter, input in_ready);
    modport slave  (input in_valid, in_data, in_tag, in_is_filter, output in_ready);
endinterface

// File: rtl/pe_mcast_feeder.sv
// Multicast feeder: buffers one tagged word from the global buffer and
// delivers it, all-or-nothing, to every enabled PE whose configured ID
// matches the tag. Per-PE, per-kind credit counters cap each ready window
// at BURST words because the PE's ready is registered and may be stale.
//   clk, rstb            : clock, synchronous active-low reset
//   cfg_we/idx/id/en     : per-PE ID / participation config write
//   up (slave)           : upstream valid/ready word stream
//   pe_ready             : per-PE ready
//   ifmap_out/filter_out : shared data buses (registered)
//   ifmap_enable/filter_enable : per-PE one-cycle load strobes (registered)
//   drop_count           : saturating count of words matching no PE
module pe_mcast_feeder #(
    parameter  int unsigned BITWIDTH  = 16,
    parameter  int unsigned NUM_PE    = 4,
    parameter  int unsigned ID_WIDTH  = 4,
    parameter  int unsigned BURST     = 3,
    parameter  int unsigned CNT_WIDTH = 8,
    localparam int unsigned IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [ID_WIDTH-1:0]  cfg_id,
    input  logic                 cfg_en,
    pe_mcast_feeder_if.slave     up,
    input  logic [NUM_PE-1:0]    pe_ready,
    output logic [BITWIDTH-1:0]  ifmap_out,
    output logic [BITWIDTH-1:0]  filter_out,
    output logic [NUM_PE-1:0]    ifmap_enable,
    output logic [NUM_PE-1:0]    filter_enable,
    output logic [CNT_WIDTH-1:0] drop_count
);
    localparam int unsigned CRD_W = $clog2(BURST + 1);

    logic [ID_WIDTH-1:0] id_q [NUM_PE];
    logic [NUM_PE-1:0]   en_q;

    logic                buf_valid_q;
    logic [BITWIDTH-1:0] buf_data_q;
    logic [ID_WIDTH-1:0] buf_tag_q;
    logic                buf_kind_q;   // 1 = filter

    logic [CRD_W-1:0]    ifm_sent_q [NUM_PE];
    logic [CRD_W-1:0]    flt_sent_q [NUM_PE];

    logic [NUM_PE-1:0]   mask_c;
    logic [NUM_PE-1:0]   eff_rdy_c;
    logic                fire_c;
    logic                in_ready_c;
    logic                accept_c;

    // Destination mask, credit-qualified ready and handshake decisions
    always_comb begin
        mask_c    = '0;
        eff_rdy_c = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            mask_c[i]    = en_q[i] && (id_q[i] == buf_tag_q);
            eff_rdy_c[i] = pe_ready[i] &&
                           ((buf_kind_q ? flt_sent_q[i] : ifm_sent_q[i]) < CRD_W'(BURST));
        end
        // An empty mask fires unconditionally (drop path)
        fire_c     = buf_valid_q && ((mask_c & ~eff_rdy_c) == '0);
        in_ready_c = rstb && (!buf_valid_q || fire_c);
        accept_c   = up.in_valid && in_ready_c;
    end

    assign up.in_ready = in_ready_c;

    // Buffer, credits, config and registered outputs
    always_ff @(posedge clk) begin
        if (!rstb) begin
            buf_valid_q   <= 1'b0;
            buf_data_q    <= '0;
            buf_tag_q     <= '0;
            buf_kind_q    <= 1'b0;
            en_q          <= '0;
            ifmap_out     <= '0;
            filter_out    <= '0;
            ifmap_enable  <= '0;
            filter_enable <= '0;
            drop_count    <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                id_q[i]       <= '0;
                ifm_sent_q[i] <= '0;
                flt_sent_q[i] <= '0;
            end
        end else begin
            ifmap_enable  <= '0;
            filter_enable <= '0;

            if (fire_c) begin
                if (mask_c == '0) begin
                    if (drop_count != '1) begin
                        drop_count <= drop_count + CNT_WIDTH'(1);
                    end
                end else if (buf_kind_q) begin
                    filter_enable <= mask_c;
                    filter_out    <= buf_data_q;
                end else begin
                    ifmap_enable  <= mask_c;
                    ifmap_out     <= buf_data_q;
                end
            end

            // Ready low refills the window; fire implies ready high so no conflict
            for (int i = 0; i < NUM_PE; i++) begin
                if (!pe_ready[i]) begin
                    ifm_sent_q[i] <= '0;
                    flt_sent_q[i] <= '0;
                end else if (fire_c && mask_c[i]) begin
                    if (buf_kind_q) begin
                        flt_sent_q[i] <= flt_sent_q[i] + CRD_W'(1);
                    end else begin
                        ifm_sent_q[i] <= ifm_sent_q[i] + CRD_W'(1);
                    end
                end
            end

            for (int i = 0; i < NUM_PE; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    id_q[i] <= cfg_id;
                    en_q[i] <= cfg_en;
                end
            end

            if (accept_c) begin
                buf_valid_q <= 1'b1;
                buf_data_q  <= up.in_data;
                buf_tag_q   <= up.in_tag;
                buf_kind_q  <= up.in_is_filter;
            end else if (fire_c) begin
                buf_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pe_mcast_feeder.sv
// Self-checking bench for pe_mcast_feeder: directed vector table, a credit
// window sequence, and randomized traffic against a behavioural model.
module tb_pe_mcast_feeder;
    localparam int unsigned BW    = 16;
    localparam int unsigned NP    = 4;
    localparam int unsigned IW    = 4;
    localparam int unsigned BURST = 3;
    localparam int unsigned CW    = 8;

    logic          clk = 1'b0;
    logic          rstb;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [IW-1:0] cfg_id;
    logic          cfg_en;
    logic [NP-1:0] pe_ready;
    logic [BW-1:0] ifmap_out;
    logic [BW-1:0] filter_out;
    logic [NP-1:0] ifmap_enable;
    logic [NP-1:0] filter_enable;
    logic [CW-1:0] drop_count;

    always #5 clk = ~clk;

    pe_mcast_feeder_if #(.BITWIDTH(BW), .ID_WIDTH(IW)) up_if ();

    pe_mcast_feeder #(
        .BITWIDTH(BW), .NUM_PE(NP), .ID_WIDTH(IW), .BURST(BURST), .CNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_id        (cfg_id),
        .cfg_en        (cfg_en),
        .up            (up_if),
        .pe_ready      (pe_ready),
        .ifmap_out     (ifmap_out),
        .filter_out    (filter_out),
        .ifmap_enable  (ifmap_enable),
        .filter_enable (filter_enable),
        .drop_count    (drop_count)
    );

    int total = 0;
    int bad   = 0;
    logic obs_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int       m_id [NP];
    bit       m_en [NP];
    bit       m_hold;
    int       m_data;
    int       m_tag;
    int       m_kind;
    int       m_win [NP][2];   // words delivered since that PE's ready was last low
    bit [3:0] m_ien, m_fen;
    int       m_iout, m_fout, m_drop;
    bit [3:0] m_tgt;
    bit       m_ok, m_rdy;

    task automatic model_comb();
        m_tgt = '0;
        for (int i = 0; i < NP; i++)
            if (m_en[i] && m_id[i] == m_tag) m_tgt[i] = 1'b1;
        m_ok = m_hold;
        for (int i = 0; i < NP; i++)
            if (m_tgt[i] && !(pe_ready[i] && m_win[i][m_kind] < int'(BURST))) m_ok = 1'b0;
        m_rdy = rstb && (!m_hold || m_ok);
    endtask

    task automatic model_edge();
        if (!rstb) begin
            m_hold = 1'b0; m_ien = '0; m_fen = '0;
            m_iout = 0; m_fout = 0; m_drop = 0;
            for (int i = 0; i < NP; i++) begin
                m_id[i] = 0; m_en[i] = 1'b0; m_win[i][0] = 0; m_win[i][1] = 0;
            end
            return;
        end
        m_ien = '0;
        m_fen = '0;
        if (m_ok) begin
            if (m_tgt == 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                if (m_kind == 1) begin m_fen = m_tgt; m_fout = m_data; end
                else             begin m_ien = m_tgt; m_iout = m_data; end
                for (int i = 0; i < NP; i++) if (m_tgt[i]) m_win[i][m_kind]++;
            end
        end
        for (int i = 0; i < NP; i++)
            if (!pe_ready[i]) begin m_win[i][0] = 0; m_win[i][1] = 0; end
        if (cfg_we) begin
            m_id[int'(cfg_idx)] = int'(cfg_id);
            m_en[int'(cfg_idx)] = cfg_en;
        end
        if (up_if.in_valid && m_rdy) begin
            m_hold = 1'b1;
            m_data = int'(up_if.in_data);
            m_tag  = int'(up_if.in_tag);
            m_kind = int'(up_if.in_is_filter);
        end else if (m_ok) begin
            m_hold = 1'b0;
        end
    endtask

    // One clock: in_ready sampled mid-cycle, registered outputs #1 after the edge
    task automatic tick();
        @(negedge clk);
        model_comb();
        obs_rdy = up_if.in_ready;
        chk("model_in_ready", 32'(obs_rdy), 32'(m_rdy));
        model_edge();
        @(posedge clk);
        #1;
        chk("model_ifmap_enable",  32'(ifmap_enable),  32'(m_ien));
        chk("model_filter_enable", 32'(filter_enable), 32'(m_fen));
        chk("model_ifmap_out",     32'(ifmap_out),     32'(m_iout));
        chk("model_filter_out",    32'(filter_out),    32'(m_fout));
        chk("model_drop_count",    32'(drop_count),    32'(m_drop));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int rb, we, idx, id, en, vld, data, tag, isf, rdy;
        int e_rdy, e_ien, e_fen, e_iout, e_fout, e_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rb, int we, int idx, int id, int en,
                                int vld, int data, int tag, int isf, int rdy,
                                int e_rdy, int e_ien, int e_fen, int e_iout, int e_fout, int e_drop);
        vec_t v;
        v.rb = rb; v.we = we; v.idx = idx; v.id = id; v.en = en;
        v.vld = vld; v.data = data; v.tag = tag; v.isf = isf; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_ien = e_ien; v.e_fen = e_fen;
        v.e_iout = e_iout; v.e_fout = e_fout; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic drive_idle();
        rstb = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_id = '0; cfg_en = 1'b0;
        up_if.in_valid = 1'b0; up_if.in_data = '0; up_if.in_tag = '0; up_if.in_is_filter = 1'b0;
        pe_ready = '1;
    endtask

    int seen[$];
    int nxt;

    task automatic stream_words(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            up_if.in_valid     = (nxt <= 14);
            up_if.in_data      = BW'(nxt);
            up_if.in_tag       = '0;
            up_if.in_is_filter = 1'b0;
            tick();
            if (up_if.in_valid && obs_rdy) nxt++;
            if (ifmap_enable[0]) seen.push_back(int'(ifmap_out));
        end
    endtask

    initial begin
        drive_idle();
        rstb = 1'b0;

        //          rb we ix id en  vld data      tag isf rdy      e_rdy ien     fen     iout     fout     drop
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 'hF,       0, 0,0, 0,0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1,i,i+1,1, 0,0,0,0, 'hF, 1, 0,0, 0,0, 0));
        // unicast ifmap tag 2
        tbl.push_back(mk(1, 0,0,0,0, 1,'h0007,2,0, 'hF,   1, 0,0, 0,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 'b0010,0, 7,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,0, 7,0, 0));
        // multicast filter tag 5 with PE2 not ready
        tbl.push_back(mk(1, 1,0,5,1, 0,0,0,0, 'b1011,     1, 0,0, 7,0, 0));
        tbl.push_back(mk(1, 1,1,5,1, 0,0,0,0, 'b1011,     1, 0,0, 7,0, 0));
        tbl.push_back(mk(1, 1,2,5,1, 0,0,0,0, 'b1011,     1, 0,0, 7,0, 0));
        tbl.push_back(mk(1, 1,3,1,1, 0,0,0,0, 'b1011,     1, 0,0, 7,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 1,'hFFFD,5,1, 'b1011, 1, 0,0, 7,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 1,'hFFFD,5,1, 'b1011, 0, 0,0, 7,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,'b0111, 7,'hFFFD, 0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,0, 7,'hFFFD, 0));
        // drops back-to-back
        tbl.push_back(mk(1, 0,0,0,0, 1,'h100,9,0, 'hF,    1, 0,0, 7,'hFFFD, 0));
        tbl.push_back(mk(1, 0,0,0,0, 1,'h101,9,0, 'hF,    1, 0,0, 7,'hFFFD, 1));
        tbl.push_back(mk(1, 0,0,0,0, 1,'h102,9,0, 'hF,    1, 0,0, 7,'hFFFD, 2));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,0, 7,'hFFFD, 3));
        // back-to-back filter/ifmap/filter to tag 1 (PE3)
        tbl.push_back(mk(1, 0,0,0,0, 1,'h0A1,1,1, 'hF,    1, 0,0, 7,'hFFFD, 3));
        tbl.push_back(mk(1, 0,0,0,0, 1,'h0B2,1,0, 'hF,    1, 0,'b1000, 7,'h0A1, 3));
        tbl.push_back(mk(1, 0,0,0,0, 1,'h0C3,1,1, 'hF,    1, 'b1000,0, 'h0B2,'h0A1, 3));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,'b1000, 'h0B2,'h0C3, 3));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,0, 'h0B2,'h0C3, 3));
        // hold waiting for PE3, then sync reset mid-hold
        tbl.push_back(mk(1, 0,0,0,0, 1,'h0DD,1,1, 'b0111, 1, 0,0, 'h0B2,'h0C3, 3));
        tbl.push_back(mk(1, 0,0,0,0, 1,'h0DD,1,1, 'b0111, 0, 0,0, 'h0B2,'h0C3, 3));
        tbl.push_back(mk(0, 0,0,0,0, 1,'h0DD,1,1, 'hF,    0, 0,0, 0,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,0, 0,0, 0));
        tbl.push_back(mk(1, 0,0,0,0, 0,0,0,0, 'hF,        1, 0,0, 0,0, 0));

        foreach (tbl[n]) begin
            rstb               = 1'(tbl[n].rb);
            cfg_we             = 1'(tbl[n].we);
            cfg_idx            = 2'(tbl[n].idx);
            cfg_id             = IW'(tbl[n].id);
            cfg_en             = 1'(tbl[n].en);
            up_if.in_valid     = 1'(tbl[n].vld);
            up_if.in_data      = BW'(tbl[n].data);
            up_if.in_tag       = IW'(tbl[n].tag);
            up_if.in_is_filter = 1'(tbl[n].isf);
            pe_ready           = NP'(tbl[n].rdy);
            tick();
            chk($sformatf("vec%0d_in_ready", n),      32'(obs_rdy),       32'(tbl[n].e_rdy));
            chk($sformatf("vec%0d_ifmap_enable", n),  32'(ifmap_enable),  32'(tbl[n].e_ien));
            chk($sformatf("vec%0d_filter_enable", n), 32'(filter_enable), 32'(tbl[n].e_fen));
            chk($sformatf("vec%0d_ifmap_out", n),     32'(ifmap_out),     32'(tbl[n].e_iout));
            chk($sformatf("vec%0d_filter_out", n),    32'(filter_out),    32'(tbl[n].e_fout));
            chk($sformatf("vec%0d_drop_count", n),    32'(drop_count),    32'(tbl[n].e_drop));
        end

        // Credit window: only PE0 enabled (id 0), ready held high
        drive_idle();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_id = '0; cfg_en = 1'b1;
        tick();
        cfg_we = 1'b0;
        nxt = 10;
        stream_words(8);
        chk("credit_pulses", 32'(seen.size()), 32'd3);
        for (int k = 0; k < 3 && k < seen.size(); k++)
            chk($sformatf("credit_word%0d", k), 32'(seen[k]), 32'(10 + k));
        chk("credit_stall_ready", 32'(obs_rdy), 32'd0);
        chk("credit_next_word",   32'(nxt),     32'd14);
        pe_ready = 4'b1110;
        stream_words(1);
        pe_ready = 4'b1111;
        stream_words(4);
        chk("refill_pulses", 32'(seen.size()), 32'd5);
        if (seen.size() == 5) begin
            chk("refill_word13", 32'(seen[3]), 32'd13);
            chk("refill_word14", 32'(seen[4]), 32'd14);
        end

        // Randomized traffic against the model
        drive_idle();
        rstb = 1'b0;
        tick();
        for (int c = 0; c < 1500; c++) begin
            rstb    = ($urandom_range(99) != 0);
            cfg_we  = ($urandom_range(9) == 0);
            cfg_idx = 2'($urandom_range(3));
            cfg_id  = IW'($urandom_range(3));
            cfg_en  = ($urandom_range(3) != 0);
            if (!(up_if.in_valid && !obs_rdy)) begin
                up_if.in_valid     = ($urandom_range(3) != 0);
                up_if.in_data      = BW'($urandom);
                up_if.in_tag       = IW'($urandom_range(4));
                up_if.in_is_filter = 1'($urandom_range(1));
            end
            for (int i = 0; i < NP; i++) pe_ready[i] = ($urandom_range(4) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
